// File: rtl/fa_cache_pkg.sv
// Shared types and constants for the fully-associative cache.
// Optional hit/miss statistics are enabled by defining FA_CACHE_STATS_EN.
package fa_cache_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } fa_state_e;

    localparam int unsigned STATS_WIDTH = 32;

endpackage

// File: rtl/fa_cache_match.sv
// Parallel tag compare across all lines plus one-hot to index encode.
// Relies on the cache never holding two valid lines with the same tag.
module fa_cache_match #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned IDX_W      = $clog2(ENTRIES)
) (
    input  logic [ENTRIES*ADDR_WIDTH-1:0] i_tags,
    input  logic [ENTRIES-1:0]            i_valid,
    input  logic [ADDR_WIDTH-1:0]         i_addr,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx
);

    logic [ENTRIES-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            w_match[i] = i_valid[i] && (i_tags[i*ADDR_WIDTH +: ADDR_WIDTH] == i_addr);
        end
    end

    // OR-reduce encode is exact because at most one bit of w_match is set.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (w_match[i]) begin
                hit_idx = hit_idx | IDX_W'(i);
            end
        end
    end

    assign hit = |w_match;

endmodule

// File: rtl/fa_cache.sv
// Fully-associative tag/data cache with FIFO replacement and sequential flush.
// Define FA_CACHE_STATS_EN to add 32-bit hit_count / miss_count outputs.
module fa_cache
    import fa_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ENTRIES    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic                      flush,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [$clog2(ENTRIES):0]  occupancy
`ifdef FA_CACHE_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]    hit_count,
    output logic [STATS_WIDTH-1:0]    miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;

    fa_state_e                            r_state;
    fa_state_e                            w_state_next;
    logic [ENTRIES-1:0]                   r_valid;
    logic [ENTRIES-1:0][ADDR_WIDTH-1:0]   r_tags;
    logic [ENTRIES-1:0][DATA_WIDTH-1:0]   r_data;
    logic [IDX_W-1:0]                     r_wr_ptr;
    logic [IDX_W-1:0]                     r_flush_idx;
    logic                                 r_rsp_valid;
    logic                                 r_rsp_hit;
    logic [DATA_WIDTH-1:0]                r_rsp_rdata;

    logic                                 w_accept;
    logic                                 w_hit;
    logic [IDX_W-1:0]                     w_hit_idx;
    logic [DATA_WIDTH-1:0]                w_hit_data;
    logic                                 w_flush_last;
    logic [OCC_W-1:0]                     w_occ;

    fa_cache_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (ENTRIES),
        .IDX_W      (IDX_W)
    ) u_match (
        .i_tags  (r_tags),
        .i_valid (r_valid),
        .i_addr  (req_addr),
        .hit     (w_hit),
        .hit_idx (w_hit_idx)
    );

    assign req_ready    = (r_state == IDLE) && !flush;
    assign w_accept     = req_valid && req_ready;
    assign w_hit_data   = r_data[w_hit_idx];
    assign w_flush_last = (r_flush_idx == IDX_W'(ENTRIES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (flush) w_state_next = FLUSH;
            FLUSH:   if (w_flush_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_tags      <= '0;
            r_data      <= '0;
            r_wr_ptr    <= '0;
            r_flush_idx <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rsp_valid <= w_accept;
            r_rsp_hit   <= w_accept && w_hit;
            r_rsp_rdata <= (w_accept && !req_write && w_hit) ? w_hit_data : '0;

            if (w_accept && req_write) begin
                if (w_hit) begin
                    r_data[w_hit_idx] <= req_wdata;
                end else begin
                    // Miss fill: when full, r_wr_ptr points at the oldest line.
                    r_tags[r_wr_ptr]  <= req_addr;
                    r_data[r_wr_ptr]  <= req_wdata;
                    r_valid[r_wr_ptr] <= 1'b1;
                    r_wr_ptr          <= r_wr_ptr + IDX_W'(1);
                end
            end

            if (r_state == FLUSH) begin
                r_valid[r_flush_idx] <= 1'b0;
                r_flush_idx          <= r_flush_idx + IDX_W'(1);
                if (w_flush_last) begin
                    r_wr_ptr <= '0;
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign occupancy = w_occ;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_rdata = r_rsp_rdata;

`ifdef FA_CACHE_STATS_EN
    logic [STATS_WIDTH-1:0] r_hit_count;
    logic [STATS_WIDTH-1:0] r_miss_count;

    // Counted at accept so the totals move in step with the response strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + STATS_WIDTH'(1);
            end else begin
                r_miss_count <= r_miss_count + STATS_WIDTH'(1);
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_fa_cache.sv
// Self-checking bench for fa_cache (ENTRIES=4) against a queue-based FIFO cache model.
// Stats checks are active when FA_CACHE_STATS_EN is defined.
module tb_fa_cache;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [15:0] rsp_rdata;
    logic [2:0]  occupancy;
`ifdef FA_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: oldest line at the front of the queues.
    logic [11:0] m_tag[$];
    logic [15:0] m_data[$];
    int unsigned m_hits;
    int unsigned m_misses;

    always #5 clk = ~clk;

    fa_cache #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (16),
        .ENTRIES    (ENTRIES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_rdata  (rsp_rdata),
        .occupancy  (occupancy)
`ifdef FA_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Called at a negedge; leaves control at the following negedge.
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_tag.delete();
        m_data.delete();
        m_hits = 0;
        m_misses = 0;
    endtask

    // One request, model update and response check. Called at a negedge.
    task automatic do_req(input logic w, input logic [11:0] a, input logic [15:0] d,
                          input logic keep);
        int idx;
        logic exp_hit;
        logic [15:0] exp_rdata;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        idx = -1;
        foreach (m_tag[i]) if (m_tag[i] == a) idx = i;
        exp_hit = (idx >= 0);
        exp_rdata = (!w && exp_hit) ? m_data[idx] : 16'h0;
        if (w) begin
            if (exp_hit) begin
                m_data[idx] = d;
            end else begin
                if (m_tag.size() == ENTRIES) begin
                    void'(m_tag.pop_front());
                    void'(m_data.pop_front());
                end
                m_tag.push_back(a);
                m_data.push_back(d);
            end
        end
        if (exp_hit) m_hits++; else m_misses++;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL req_ready addr=%h got %b want 1", a, req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rsp_valid addr=%h got %b want 1", a, rsp_valid);
        end
        n_checks++;
        if (rsp_hit !== exp_hit) begin
            n_errors++;
            $display("FAIL rsp_hit w=%b addr=%h got %b want %b", w, a, rsp_hit, exp_hit);
        end
        n_checks++;
        if (rsp_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL rsp_rdata w=%b addr=%h got %h want %h", w, a, rsp_rdata, exp_rdata);
        end
        n_checks++;
        if (occupancy !== 3'(m_tag.size())) begin
            n_errors++;
            $display("FAIL occupancy addr=%h got %0d want %0d", a, occupancy, m_tag.size());
        end
`ifdef FA_CACHE_STATS_EN
        n_checks++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            n_errors++;
            $display("FAIL stats got %0d/%0d want %0d/%0d", hit_count, miss_count,
                     m_hits, m_misses);
        end
`endif
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 ||
            rsp_rdata !== 16'h0 || occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_state got rdy=%b v=%b h=%b d=%h occ=%0d want 1 0 0 0000 0",
                     req_ready, rsp_valid, rsp_hit, rsp_rdata, occupancy);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_read_empty();
        do_reset();
        do_req(1'b0, 12'h055, 16'h0, 1'b0);
        // Single accept must give a single-cycle strobe.
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rsp_single_cycle got %b want 0", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_reset();
        do_req(1'b1, 12'h010, 16'hAAAA, 1'b0);
        do_req(1'b0, 12'h010, 16'h0, 1'b0);
    endtask

    task automatic test_evict();
        do_reset();
        for (int i = 1; i <= 5; i++) do_req(1'b1, 12'(i), 16'(i * 16'h1111), 1'b1);
        do_req(1'b0, 12'h001, 16'h0, 1'b1);
        do_req(1'b0, 12'h005, 16'h0, 1'b0);
    endtask

    task automatic test_overwrite();
        do_reset();
        do_req(1'b1, 12'h002, 16'h2222, 1'b0);
        do_req(1'b1, 12'h002, 16'hBEEF, 1'b0);
        do_req(1'b0, 12'h002, 16'h0, 1'b0);
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < ENTRIES; i++) do_req(1'b1, 12'(16 + i), 16'(16'h0A00 + i), 1'b0);
        do_req(1'b0, 12'h013, 16'h0, 1'b0);
        // Cycle after an accept: flush plus a competing request.
        do_req(1'b0, 12'h011, 16'h0, 1'b1);
        flush = 1'b1;
        req_addr = 12'h010;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_priority rsp_valid got %b want 0", rsp_valid);
        end
        for (int k = 0; k < ENTRIES; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = (k == 1);
            #1;
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_busy cycle %0d req_ready got %b want 0", k, req_ready);
            end
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL flush_done got rdy=%b occ=%0d want 1 0", req_ready, occupancy);
        end
        m_tag.delete();
        m_data.delete();
        for (int i = 0; i < ENTRIES; i++) do_req(1'b0, 12'(16 + i), 16'h0, 1'b0);
        do_req(1'b1, 12'h077, 16'h7777, 1'b0);
        do_req(1'b0, 12'h077, 16'h0, 1'b0);
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        for (int i = 0; i < 3; i++) do_req(1'b1, 12'(32 + i), 16'(i + 1), 1'b0);
        do_req(1'b0, 12'h020, 16'h0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || occupancy !== 3'd0 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_flush got rdy=%b occ=%0d v=%b want 1 0 0",
                     req_ready, occupancy, rsp_valid);
        end
`ifdef FA_CACHE_STATS_EN
        n_checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        do_reset();
        do_req(1'b0, 12'h021, 16'h0, 1'b0);
    endtask

    task automatic test_back_to_back_random();
        logic keep;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            keep = ($urandom_range(0, 3) != 0);
            do_req(1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)),
                   16'($urandom), keep);
            if (!keep) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (rsp_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL idle_rsp_valid iter %0d got %b want 0", n, rsp_valid);
                end
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_write_read();
        test_evict();
        test_overwrite();
        test_flush();
        test_reset_in_flush();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fa_cache.md
FA_CACHE -- requirements
Module: fa_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data word width in bits.
REQ-003 SHALL have parameter ENTRIES, default 16, number of fully-associative lines; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit, request present.
REQ-007 SHALL have port req_ready, output, 1 bit, request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write/fill, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits, lookup tag.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits, write data.
REQ-011 SHALL have port flush, input, 1 bit, invalidate-all request.
REQ-012 SHALL have port rsp_valid, output, 1 bit, one-cycle response strobe.
REQ-013 SHALL have port rsp_hit, output, 1 bit, tag matched a valid line.
REQ-014 SHALL have port rsp_rdata, output, DATA_WIDTH bits, read data.
REQ-015 SHALL have port occupancy, output, $clog2(ENTRIES)+1 bits, count of valid lines.

Function
REQ-016 SHALL implement states IDLE and FLUSH; req_ready = (state==IDLE) && !flush, combinational.
REQ-017 SHALL, on accept, compare req_addr against all valid lines in parallel; at most one line matches.
REQ-018 SHALL assert rsp_valid exactly one cycle after accept, for one cycle; back-to-back accepts give back-to-back responses.
REQ-019 SHALL, on read hit, return rsp_hit=1 and the line data; on read miss, rsp_hit=0 and rsp_rdata=0; no state change.
REQ-020 SHALL, on write hit, overwrite the matching line's data in place, rsp_hit=1, rsp_rdata=0; wr_ptr unchanged.
REQ-021 SHALL, on write miss, fill line wr_ptr (tag, data, valid=1), increment wr_ptr modulo ENTRIES, rsp_hit=0, rsp_rdata=0.
REQ-022 SHALL saturate occupancy at ENTRIES; a write miss when full evicts the oldest line (FIFO) and leaves occupancy unchanged.
REQ-023 SHALL, on flush in IDLE, enter FLUSH, clearing one valid bit per cycle from index 0 to ENTRIES-1 (ENTRIES cycles), then return to IDLE with wr_ptr=0 and occupancy=0.
REQ-024 SHALL give flush priority over a simultaneous req_valid: the request is not accepted; flush asserted during FLUSH is ignored.
REQ-025 SHALL still emit the response of a request accepted the cycle before flush.

Reset
REQ-026 SHALL, with rst high at a clock edge, clear all valid bits, tags and data; set wr_ptr=0, occupancy=0, state=IDLE, rsp_valid=0, rsp_hit=0, rsp_rdata=0; this aborts a flush or a pending response.

Configuration
REQ-027 SHALL, with FA_CACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each) counting rsp_hit=1 / rsp_hit=0 responses, wrapping at 2^32, cleared by rst but not by flush; without the macro these ports and counters SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-028 SHALL put the state enum (IDLE, FLUSH) and the stats counter width constant in package fa_cache_pkg.
REQ-029 SHALL put the parallel tag compare and one-hot-to-index encode in sub-module fa_cache_match (outputs hit, hit_idx).

Verification (ENTRIES=4, ADDR_WIDTH=12, DATA_WIDTH=16)
REQ-030 SHALL cover: write 0x010=0xAAAA, then read 0x010 -> rsp_hit=1, rsp_rdata=0xAAAA, occupancy=1.
REQ-031 SHALL cover: read 0x055 on empty cache -> rsp_hit=0, rsp_rdata=0, occupancy=0.
REQ-032 SHALL cover: write 0x001..0x005 with data 0x1111..0x5555 -> read 0x001 misses, read 0x005 returns 0x5555, occupancy=4.
REQ-033 SHALL cover: write 0x002=0x2222, then write 0x002=0xBEEF -> occupancy stays 1, read returns 0xBEEF.
REQ-034 SHALL cover: fill 4 lines, pulse flush together with req_valid -> req_ready=0 for 4 cycles, then occupancy=0 and all reads miss.
REQ-035 SHALL cover: rst asserted during FLUSH -> next cycle state IDLE, req_ready=1, occupancy=0; with FA_CACHE_STATS_EN, hit_count=0 and miss_count=0.
